acc_stream_master: RTL

ACC_STREAM_MASTER -- requirements
Module: acc_stream_master

---
 rtl/acc_pkg.sv | 19 +
 rtl/acc_addr_gen.sv | 14 +
 rtl/acc_stream_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulate/argmax accelerator and its stream master:
// default widths and the master FSM state encoding.
package acc_pkg;

    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_ADDRWIDTH = 16;
    localparam int DEF_TIMEOUT   = 1024;
    localparam int RESULT_W      = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_M      = 3'd1,
        RD_N      = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4,
        FINISH    = 3'd5
    } acc_state_t;

endpackage

// File: rtl/acc_addr_gen.sv
// Operand address generator: base plus element index, wrapping modulo 2^ADDRWIDTH.
module acc_addr_gen
    import acc_pkg::*;
#(
    parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
    input  logic [ADDRWIDTH-1:0] base,
    input  logic [ADDRWIDTH-1:0] idx,
    output logic [ADDRWIDTH-1:0] addr
);

    assign addr = base + idx;

endmodule

// File: rtl/acc_stream_master.sv
// Streams operand pairs (Rm[i], Rn[i]) from data memory into the accelerator,
// then waits for its done strobe (bounded by TIMEOUT) and reports the result.
module acc_stream_master
    import acc_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDRWIDTH-1:0]        base_m,
    input  logic [ADDRWIDTH-1:0]        base_n,
    input  logic [ADDRWIDTH-1:0]        length,
    output logic                        mem_re,
    output logic [ADDRWIDTH-1:0]        mem_addr,
    input  logic [DATAWIDTH-1:0]        mem_rdata,
    output logic signed [DATAWIDTH-1:0] Rm,
    output logic signed [DATAWIDTH-1:0] Rn,
    output logic                        op_valid,
    output logic                        op_last,
    output logic                        acc_clr,
    input  logic                        acc_done,
    input  logic signed [RESULT_W-1:0]  max_index,
    output logic                        busy,
    output logic signed [RESULT_W-1:0]  result,
    output logic                        result_valid,
    output logic                        error,
    output acc_state_t                  dbg_state
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    acc_state_t           state, state_next;
    logic [ADDRWIDTH-1:0] base_m_q, base_n_q, length_q, idx;
    logic [CNT_W-1:0]     cnt;
    logic                 is_last, timed_out, load_addr;
    logic [ADDRWIDTH-1:0] gen_base, gen_idx, gen_addr;

    assign is_last   = (idx == length_q - ADDRWIDTH'(1));
    assign timed_out = (cnt == CNT_LAST);
    assign busy      = (state != IDLE);
    assign mem_re    = (state == RD_M) || (state == RD_N);
    assign dbg_state = state;

    acc_addr_gen #(.ADDRWIDTH(ADDRWIDTH)) u_addr_gen (
        .base (gen_base),
        .idx  (gen_idx),
        .addr (gen_addr)
    );

    // mem_addr is registered, so the address for the next read state is
    // computed on the transition into it and simply held everywhere else.
    always_comb begin
        state_next = state;
        load_addr  = 1'b0;
        gen_base   = base_m_q;
        gen_idx    = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_next = RD_M;
                        load_addr  = 1'b1;
                        gen_base   = base_m;
                        gen_idx    = '0;
                    end else begin
                        state_next = FINISH;
                    end
                end
            end
            RD_M: begin
                state_next = RD_N;
                load_addr  = 1'b1;
                gen_base   = base_n_q;
            end
            RD_N: state_next = ISSUE;
            ISSUE: begin
                if (is_last) begin
                    state_next = WAIT_DONE;
                end else begin
                    state_next = RD_M;
                    load_addr  = 1'b1;
                    gen_idx    = idx + ADDRWIDTH'(1);
                end
            end
            WAIT_DONE: if (acc_done || timed_out) state_next = FINISH;
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Rn lands on the edge that closes ISSUE, so the pair strobe is registered
    // alongside it: the accelerator sees op_valid with both operands settled.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            base_m_q     <= '0;
            base_n_q     <= '0;
            length_q     <= '0;
            idx          <= '0;
            cnt          <= '0;
            mem_addr     <= '0;
            Rm           <= '0;
            Rn           <= '0;
            op_valid     <= 1'b0;
            op_last      <= 1'b0;
            acc_clr      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            acc_clr      <= (state == IDLE) && start;
            op_valid     <= (state == ISSUE);
            op_last      <= (state == ISSUE) && is_last;
            result_valid <= (state == FINISH);
            if (load_addr) mem_addr <= gen_addr;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_m_q <= base_m;
                        base_n_q <= base_n;
                        length_q <= length;
                        idx      <= '0;
                        error    <= (length == '0);
                    end
                end
                RD_N: Rm <= $signed(mem_rdata);
                ISSUE: begin
                    Rn  <= $signed(mem_rdata);
                    cnt <= '0;
                    if (!is_last) idx <= idx + ADDRWIDTH'(1);
                end
                WAIT_DONE: begin
                    // A done strobe in the expiry cycle takes priority over the timeout.
                    if (acc_done)       result <= max_index;
                    else if (timed_out) error  <= 1'b1;
                    else                cnt    <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
